// File: rtl/code_fetch_bridge_if.sv
// Instruction-cache line-fill port: word read requests toward the code fetch bridge.
// The icache is the master, the bridge is the slave.
interface code_fetch_bridge_if #(
   parameter int ADDRLEN = 24
);
   logic                 code_rd;
   logic [ADDRLEN-3:0]   code_addr;
   logic                 code_valid;
   logic [31:0]          code_data;

   modport master (
      output code_rd,
      output code_addr,
      input  code_valid,
      input  code_data
   );

   modport slave (
      input  code_rd,
      input  code_addr,
      output code_valid,
      output code_data
   );
endinterface

// File: rtl/code_fetch_bridge.sv
// Serves icache word reads as four little-endian byte reads from a byte-wide
// code memory with programmable wait states per byte access.
module code_fetch_bridge #(
   parameter int ADDRLEN = 24
) (
   input  logic                clk,
   input  logic                rst,
   code_fetch_bridge_if.slave  code,
   input  logic [3:0]          wait_cfg,
   output logic                mem_cs,
   output logic [ADDRLEN-1:0]  mem_addr,
   input  logic [7:0]          mem_rdata,
   output logic                busy,
   output logic [15:0]         word_count
);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      VALID
   } state_t;

   state_t              state;
   logic [ADDRLEN-3:0]  waddr;
   logic [3:0]          wcfg;
   logic [3:0]          wcnt;
   logic [1:0]          byte_idx;
   logic                code_valid_q;
   logic [31:0]         code_data_q;

   assign code.code_valid = code_valid_q;
   assign code.code_data  = code_data_q;

   // NOTE: every register here is state, so all assignments are non-blocking;
   // a blocking write would let later statements see the new value in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         waddr        <= '0;
         wcfg         <= '0;
         wcnt         <= '0;
         byte_idx     <= '0;
         code_valid_q <= 1'b0;
         code_data_q  <= '0;
         mem_cs       <= 1'b0;
         mem_addr     <= '0;
         busy         <= 1'b0;
         word_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_cs <= 1'b0;
               if (code.code_rd) begin
                  waddr    <= code.code_addr;
                  wcfg     <= wait_cfg;
                  wcnt     <= wait_cfg;
                  byte_idx <= 2'd0;
                  mem_cs   <= 1'b1;
                  mem_addr <= {code.code_addr, 2'b00};
                  busy     <= 1'b1;
                  state    <= RD;
               end
            end

            RD: begin
               if (!code.code_rd) begin
                  // Abort: partial bytes stay in code_data, no delivery is counted.
                  mem_cs <= 1'b0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (wcnt != 4'd0) begin
                  wcnt <= wcnt - 4'd1;
               end else begin
                  code_data_q[{byte_idx, 3'b000} +: 8] <= mem_rdata;
                  if (byte_idx == 2'd3) begin
                     mem_cs       <= 1'b0;
                     code_valid_q <= 1'b1;
                     if (word_count != 16'hFFFF) begin
                        word_count <= word_count + 16'd1;
                     end
                     state <= VALID;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                     wcnt     <= wcfg;
                     mem_addr <= {waddr, byte_idx + 2'd1};
                  end
               end
            end

            VALID: begin
               // Returning through IDLE gives the icache one edge to advance code_addr.
               code_valid_q <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end

            default: begin
               code_valid_q <= 1'b0;
               mem_cs       <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/code_fetch_bridge.md
Name: code_fetch_bridge

Overview:
- Serves word read requests from the instruction cache line-fill port (code_rd / code_addr / code_valid / code_data).
- Fetches each 32-bit word as four byte reads from an external byte-wide code memory (parallel flash/ROM) with programmable wait states.
- Assembles the bytes little-endian and returns the word with a one-cycle code_valid pulse.
- Sits directly downstream of the icache, between it and the code memory pads.

Parameters:
ADDRLEN, 24, byte address width of the code space; code_addr is the word address ADDRLEN-2 bits wide.

Ports:
clk  input  1  block clock, same clock as the icache core clock
rst  input  1  reset, asynchronous, active-high
code_rd  input  1  word read request from the icache; held high across a line fill
code_addr  input  ADDRLEN-2  word address of the request
code_valid  output  1  one-cycle pulse; code_data holds the requested word
code_data  output  32  assembled word; byte 0 is in [7:0]
wait_cfg  input  4  wait states per byte access; sampled at the start of each word
mem_cs  output  1  external memory chip select / read strobe
mem_addr  output  ADDRLEN  external byte address
mem_rdata  input  8  external memory read data; sampled at the end of the last wait cycle
busy  output  1  high in any state other than IDLE
word_count  output  16  saturating count of delivered words; for debug and verification

Behaviour:
- Reset (async, rst=1) values: state=IDLE, code_valid=0, code_data=0, mem_cs=0, mem_addr=0, busy=0, word_count=0, byte index=0, wait counter=0.
- States: IDLE, RD, VALID.
- IDLE:
  - If code_rd=1: latch code_addr into waddr, latch wait_cfg into wcfg, set byte=0, wcnt=wait_cfg, go to RD.
  - Else stay in IDLE.
  - mem_cs=0 in IDLE.
- RD:
  - mem_cs=1, mem_addr={waddr,byte}; both are registered.
  - If wcnt!=0: wcnt decrements.
  - If wcnt==0:
    - Capture mem_rdata into code_data[byte*8+:8].
    - If byte==3: go to VALID.
    - Else: byte increments and wcnt reloads from wcfg.
- VALID:
  - code_valid=1 for exactly this cycle; mem_cs=0; word_count increments (saturates at 16'hFFFF).
  - Go to IDLE.
- code_data ownership:
  - code_data is stable while code_valid=1.
  - It holds its value until the next byte capture. Lanes not yet overwritten keep stale data; they are only valid during code_valid.
- Latency:
  - With wait_cfg=W and code_rd first high in cycle T, mem_cs is high in cycles T+1 .. T+4(W+1).
  - code_valid is high in cycle T+4(W+1)+1.
  - The next word starts no earlier than 2 cycles after code_valid: VALID, then IDLE. This guarantees the icache's code_addr increment, which it makes on the code_valid edge, is visible before IDLE samples it.
- Line fill: 8 consecutive requests; the icache drops code_rd on the edge after the 8th code_valid, so IDLE then sees code_rd=0 and stays idle.
- Abort:
  - If code_rd=0 in any RD cycle, go to IDLE next cycle: no code_valid, no word_count change, mem_cs=0.
  - The partial code_data bytes are not cleared.
- wait_cfg changes mid-word have no effect until the next word.
- mem_addr wrap: waddr at all-ones and byte=3 gives mem_addr all-ones; no carry beyond ADDRLEN.
- Reset asserted mid-word:
  - All outputs return to reset values immediately (asynchronously).
  - After release, the block restarts from IDLE and refetches if code_rd is still high.
- code_rd high in VALID is ignored until IDLE.

Test Plan:
- Single word: wait_cfg=0, code_addr=0x000010, memory byte k=k[7:0] -> mem_addr 0x40,0x41,0x42,0x43 in four consecutive cycles; code_valid 5 cycles after the request edge; code_data=0x43424140; word_count=1.
- Wait states: wait_cfg=2, same request -> each mem_addr held 3 cycles; code_valid at cycle 13; identical code_data.
- Full line fill: icache-style driver, code_addr 0x000008..0x00000F, wait_cfg=0, code_rd dropped after the 8th valid -> 8 code_valid pulses spaced 6 cycles apart; words match memory at 0x20..0x3F; word_count=8; busy=0 afterwards.
- Abort: code_rd deasserted while byte 1 is in RD -> no code_valid; state IDLE next cycle; mem_cs=0; word_count unchanged.
- Reset mid-fetch: rst pulsed during byte 2 -> code_valid=0, code_data=0, mem_cs=0 immediately; with code_rd still high after release, the full word is refetched from byte 0 and delivered correctly.
- Boundaries: code_addr all-ones with wait_cfg=15 -> last mem_addr 0xFFFFFF; each byte held 16 cycles; code_valid at cycle 65. word_count preloaded near saturation via 65536+ deliveries (or forced) stays at 0xFFFF.
